// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory byte-stream loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_COUNT   = 3'd2,
        ST_DATA_HI = 3'd3,
        ST_DATA_LO = 3'd4,
        ST_CHK     = 3'd5,
        ST_DONE    = 3'd6
    } state_e;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    localparam int BYTE_CNT_W = 2;
    localparam logic [BYTE_CNT_W-1:0] BYTE_CNT_ZERO   = 2'd0;
    localparam logic [BYTE_CNT_W-1:0] BYTE_CNT_ONE    = 2'd1;
    localparam logic [BYTE_CNT_W-1:0] ADDR_LAST_BYTE  = 2'd3;
    localparam logic [BYTE_CNT_W-1:0] COUNT_LAST_BYTE = 2'd1;

    function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] data_byte);
        return acc ^ data_byte;
    endfunction

endpackage

// File: rtl/imem_word_assembler.sv
// Pairs high/low bytes into a 16-bit instruction word and issues a one-cycle
// registered write strobe carrying the address captured with the low byte.
module imem_word_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        hi_load,
    input  logic        lo_load,
    input  logic [7:0]  data_byte,
    input  logic [31:0] addr,
    output logic        write_enable,
    output logic [31:0] write_addr,
    output logic [15:0] write_data
);

    logic [7:0] hi_r;

    // Byte pairing and write-strobe generation.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hi_r         <= 8'd0;
            write_enable <= 1'b0;
            write_addr   <= 32'd0;
            write_data   <= 16'd0;
        end else begin
            write_enable <= lo_load;
            if (hi_load) begin
                hi_r <= data_byte;
            end
            if (lo_load) begin
                write_data <= {hi_r, data_byte};
                write_addr <= addr;
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader for instruction memory; holds the fetch stage in
// reset until a frame completes. Trailing checksum enabled by IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        write_enable_fm,
    output logic [31:0] write_addr_fm,
    output logic [15:0] write_data_fm,
    output logic        rst_fm,
    output logic        done,
    output logic        error,
    output logic [15:0] load_count
);

    state_e                state_r;
    logic [BYTE_CNT_W-1:0] byte_cnt_r;
    logic [31:0]           addr_r;
    logic [15:0]           count_r;
    logic [15:0]           load_count_r;
    logic                  rx_ready_r;
    logic                  rst_fm_r;
    logic                  done_r;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]            csum_r;
    logic                  error_r;
`endif

    logic        accept_s;
    logic        last_word_s;
    logic        hi_load_s;
    logic        lo_load_s;
    logic [15:0] count_next_s;

    assign accept_s     = rx_valid & rx_ready_r;
    assign count_next_s = {count_r[7:0], rx_data};
    assign last_word_s  = ((load_count_r + 16'd1) == count_r);
    assign hi_load_s    = accept_s && (state_r == ST_DATA_HI);
    assign lo_load_s    = accept_s && (state_r == ST_DATA_LO);

    imem_word_assembler u_word_assembler (
        .clk          (clk),
        .reset        (reset),
        .hi_load      (hi_load_s),
        .lo_load      (lo_load_s),
        .data_byte    (rx_data),
        .addr         (addr_r),
        .write_enable (write_enable_fm),
        .write_addr   (write_addr_fm),
        .write_data   (write_data_fm)
    );

    // Frame parser: header fields, word counting, completion and fetch-reset control.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            byte_cnt_r   <= BYTE_CNT_ZERO;
            addr_r       <= 32'd0;
            count_r      <= 16'd0;
            load_count_r <= 16'd0;
            rx_ready_r   <= 1'b1;
            rst_fm_r     <= 1'b1;
            done_r       <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_r       <= 8'd0;
            error_r      <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s && (rx_data == SYNC_BYTE)) begin
                        state_r      <= ST_ADDR;
                        byte_cnt_r   <= BYTE_CNT_ZERO;
                        load_count_r <= 16'd0;
                        rst_fm_r     <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_r       <= 8'd0;
                        error_r      <= 1'b0;
`endif
                    end
                end
                ST_ADDR: begin
                    if (accept_s) begin
                        addr_r     <= {addr_r[23:0], rx_data};
                        byte_cnt_r <= byte_cnt_r + BYTE_CNT_ONE;
                        if (byte_cnt_r == ADDR_LAST_BYTE) begin
                            state_r    <= ST_COUNT;
                            byte_cnt_r <= BYTE_CNT_ZERO;
                        end
                    end
                end
                ST_COUNT: begin
                    if (accept_s) begin
                        count_r    <= count_next_s;
                        byte_cnt_r <= byte_cnt_r + BYTE_CNT_ONE;
                        if (byte_cnt_r == COUNT_LAST_BYTE) begin
                            byte_cnt_r <= BYTE_CNT_ZERO;
                            if (count_next_s != 16'd0) begin
                                state_r <= ST_DATA_HI;
                            end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                state_r <= ST_CHK;
`else
                                state_r    <= ST_DONE;
                                done_r     <= 1'b1;
                                rst_fm_r   <= 1'b0;
                                rx_ready_r <= 1'b0;
`endif
                            end
                        end
                    end
                end
                ST_DATA_HI: begin
                    if (accept_s) begin
                        state_r <= ST_DATA_LO;
                    end
                end
                ST_DATA_LO: begin
                    if (accept_s) begin
                        addr_r       <= addr_r + 32'd1;
                        load_count_r <= load_count_r + 16'd1;
                        if (!last_word_s) begin
                            state_r <= ST_DATA_HI;
                        end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state_r <= ST_CHK;
`else
                            state_r    <= ST_DONE;
                            done_r     <= 1'b1;
                            rst_fm_r   <= 1'b0;
                            rx_ready_r <= 1'b0;
`endif
                        end
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                ST_CHK: begin
                    if (accept_s) begin
                        if (rx_data == csum_r) begin
                            state_r    <= ST_DONE;
                            done_r     <= 1'b1;
                            rst_fm_r   <= 1'b0;
                            rx_ready_r <= 1'b0;
                        end else begin
                            state_r <= ST_IDLE;
                            error_r <= 1'b1;
                        end
                    end
                end
`endif
                ST_DONE: begin
                    state_r    <= ST_IDLE;
                    rx_ready_r <= 1'b1;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    rx_ready_r <= 1'b1;
                end
            endcase
`ifdef IMEM_LOADER_CHECKSUM_EN
            // Checksum covers every byte after sync up to the last data byte.
            if (accept_s && (state_r inside {ST_ADDR, ST_COUNT, ST_DATA_HI, ST_DATA_LO})) begin
                csum_r <= csum_update(csum_r, rx_data);
            end
`endif
        end
    end

    assign rx_ready   = rx_ready_r;
    assign rst_fm     = rst_fm_r;
    assign done       = done_r;
    assign load_count = load_count_r;
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign error      = error_r;
`else
    assign error      = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: frame-level reference model with a
// write scoreboard, directed frames plus randomized frames and rx_valid gaps.
module tb_imem_loader;

    logic        clk;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        write_enable_fm;
    logic [31:0] write_addr_fm;
    logic [15:0] write_data_fm;
    logic        rst_fm;
    logic        done;
    logic        error;
    logic [15:0] load_count;

    int total = 0;
    int bad   = 0;
    int done_seen = 0;
    int done_exp  = 0;
    logic prev_we = 1'b0;

    logic [31:0] exp_addr_q[$];
    logic [15:0] exp_data_q[$];
    logic [7:0]  frame_q[$];
    logic [7:0]  lit_q[$];
    logic [15:0] wbuf [0:7];

    imem_loader #(.SYNC_BYTE(8'hA5)) dut (
        .clk             (clk),
        .reset           (reset),
        .rx_data         (rx_data),
        .rx_valid        (rx_valid),
        .rx_ready        (rx_ready),
        .write_enable_fm (write_enable_fm),
        .write_addr_fm   (write_addr_fm),
        .write_data_fm   (write_data_fm),
        .rst_fm          (rst_fm),
        .done            (done),
        .error           (error),
        .load_count      (load_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Write scoreboard and per-cycle output checks.
    always @(negedge clk) begin
        if (write_enable_fm === 1'b1) begin
            if (exp_addr_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                         write_addr_fm, write_data_fm);
            end else begin
                chk("write_addr", write_addr_fm, exp_addr_q.pop_front());
                chk("write_data", 32'(write_data_fm), 32'(exp_data_q.pop_front()));
            end
            if (prev_we === 1'b1) begin
                total++;
                bad++;
                $display("FAIL write_spacing: got writes in consecutive cycles, expected gap");
            end
        end
        if (done === 1'b1) done_seen++;
`ifndef IMEM_LOADER_CHECKSUM_EN
        chk("error_tied", 32'(error), 32'd0);
`endif
        prev_we = write_enable_fm;
    end

    task automatic check_reset();
        chk("rst_rx_ready",   32'(rx_ready), 32'd1);
        chk("rst_we",         32'(write_enable_fm), 32'd0);
        chk("rst_waddr",      write_addr_fm, 32'd0);
        chk("rst_wdata",      32'(write_data_fm), 32'd0);
        chk("rst_rst_fm",     32'(rst_fm), 32'd1);
        chk("rst_done",       32'(done), 32'd0);
        chk("rst_error",      32'(error), 32'd0);
        chk("rst_load_count", 32'(load_count), 32'd0);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int guard;
        if (gap > 0) begin
            rx_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        rx_data  = b;
        rx_valid = 1'b1;
        guard    = 0;
        while (rx_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: got rx_ready low for 50 cycles, expected ready");
        end
        @(negedge clk);
    endtask

    // Model: serialise a frame from its fields.
    task automatic build_frame(input logic [31:0] addr, input int n, input bit bad_chk);
        logic [15:0] n16;
        logic [7:0]  cs;
        n16 = 16'(n);
        frame_q.delete();
        frame_q.push_back(8'hA5);
        for (int i = 3; i >= 0; i--) frame_q.push_back(addr[8*i +: 8]);
        frame_q.push_back(n16[15:8]);
        frame_q.push_back(n16[7:0]);
        for (int i = 0; i < n; i++) begin
            frame_q.push_back(wbuf[i][15:8]);
            frame_q.push_back(wbuf[i][7:0]);
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        cs = 8'd0;
        for (int i = 1; i < frame_q.size(); i++) cs = cs ^ frame_q[i];
        if (bad_chk) cs = cs ^ 8'h01;
        frame_q.push_back(cs);
`else
        cs = 8'd0;
        if (bad_chk) cs = 8'd1;
        if (cs != 8'd0) $display("note: checksum disabled, bad_chk ignored");
`endif
    endtask

    task automatic expect_writes(input logic [31:0] addr, input int n);
        for (int i = 0; i < n; i++) begin
            exp_addr_q.push_back(addr + 32'(i));
            exp_data_q.push_back(wbuf[i]);
        end
    endtask

    task automatic send_frame_q(input int maxgap, input int upto);
        for (int i = 0; i < upto; i++)
            send_byte(frame_q[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    endtask

    task automatic finish_frame(input int n, input bit bad_chk);
        logic good;
        good = !bad_chk;
        chk("done_pulse",  32'(done), 32'(good));
        chk("rst_fm_end",  32'(rst_fm), 32'(!good));
        chk("error_end",   32'(error), 32'(bad_chk));
        chk("rx_ready_end", 32'(rx_ready), 32'(!good));
        chk("load_count",  32'(load_count), 32'(n));
        if (good) done_exp++;
        rx_valid = 1'b0;
        @(negedge clk);
        chk("done_width", 32'(done), 32'd0);
        chk("writes_drained", 32'(exp_addr_q.size()), 32'd0);
    endtask

    task automatic run_frame(input logic [31:0] addr, input int n, input bit bad_chk, input int maxgap);
        build_frame(addr, n, bad_chk);
        expect_writes(addr, n);
        send_frame_q(maxgap, frame_q.size());
        finish_frame(n, bad_chk);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int  n;
        bit  bad_chk;
        logic [31:0] addr;
        reset    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_reset();
        reset = 1'b1;
        @(negedge clk);
        check_reset();

        // Garbage before sync: consumed, ignored.
        send_byte(8'h00, 0);
        send_byte(8'hFF, 0);
        send_byte(8'h12, 0);
        rx_valid = 1'b0;
        @(negedge clk);
        chk("garbage_rst_fm", 32'(rst_fm), 32'd1);
        chk("garbage_done", 32'(done_seen), 32'd0);

        // Hand-written frame pins the model serialiser.
        lit_q = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
`ifdef IMEM_LOADER_CHECKSUM_EN
        lit_q.push_back(8'h52);
`endif
        wbuf[0] = 16'h1234;
        wbuf[1] = 16'hABCD;
        build_frame(32'h10, 2, 1'b0);
        chk("model_len", 32'(frame_q.size()), 32'(lit_q.size()));
        for (int i = 0; i < lit_q.size(); i++) chk("model_byte", 32'(frame_q[i]), 32'(lit_q[i]));

        // Directed frame A with literal write expectations.
        exp_addr_q.push_back(32'h10); exp_data_q.push_back(16'h1234);
        exp_addr_q.push_back(32'h11); exp_data_q.push_back(16'hABCD);
        frame_q = lit_q;
        send_frame_q(0, frame_q.size());
        chk("a_done",  32'(done), 32'd1);
        chk("a_rst_fm", 32'(rst_fm), 32'd0);
        chk("a_count", 32'(load_count), 32'd2);
        done_exp++;
        rx_valid = 1'b0;
        @(negedge clk);
        chk("a_drained", 32'(exp_addr_q.size()), 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Same frame, checksum 0x53: writes stay, error, no done.
        lit_q[11] = 8'h53;
        frame_q = lit_q;
        exp_addr_q.push_back(32'h10); exp_data_q.push_back(16'h1234);
        exp_addr_q.push_back(32'h11); exp_data_q.push_back(16'hABCD);
        send_frame_q(0, frame_q.size());
        finish_frame(2, 1'b1);
        repeat (3) @(negedge clk);
        chk("error_sticky", 32'(error), 32'd1);
        run_frame(32'h40, 2, 1'b0, 0);
`endif

        // Empty frame, then address wrap.
        run_frame(32'h0, 0, 1'b0, 0);
        wbuf[0] = 16'hA5A5;
        wbuf[1] = 16'h0F0F;
        run_frame(32'hFFFF_FFFF, 2, 1'b0, 0);

        // Reset after the high byte of word 1: no write may appear.
        build_frame(32'h200, 3, 1'b0);
        send_frame_q(0, 8);
        reset    = 1'b0;
        rx_valid = 1'b0;
        @(negedge clk);
        check_reset();
        reset = 1'b1;
        @(negedge clk);
        wbuf[0] = 16'h5A5A;
        wbuf[1] = 16'h00A5;
        wbuf[2] = 16'hBEEF;
        run_frame(32'h300, 3, 1'b0, 0);

        // Random frames, each sent gap-free and then with rx_valid gaps.
        for (int k = 0; k < 10; k++) begin
            n    = int'($urandom_range(0, 6));
            addr = ((k % 3) == 0) ? 32'hFFFF_FFFD : 32'($urandom);
            for (int i = 0; i < n; i++)
                wbuf[i] = ($urandom_range(0, 3) == 0) ? 16'hA5A5 : 16'($urandom);
`ifdef IMEM_LOADER_CHECKSUM_EN
            bad_chk = ($urandom_range(0, 3) == 0);
`else
            bad_chk = 1'b0;
`endif
            run_frame(addr, n, bad_chk, 0);
            run_frame(addr, n, bad_chk, 3);
        end

        repeat (3) @(negedge clk);
        chk("done_total", 32'(done_seen), 32'(done_exp));
        chk("final_drained", 32'(exp_addr_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
